rr_burst_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port datapath resource (write port/bus) between N requesters.
- A grant is locked for a whole burst of requester-declared length; the grant releases after the last beat is acknowledged by the resource.
- Sits between requester front-ends and the shared resource; owns fairness and burst sequencing only, not the data muxing.

---
 rtl/rr_burst_arbiter_pkg.sv | 47 ++++
 rtl/rr_burst_arbiter_if.sv | 40 ++++
 rtl/rr_burst_arbiter_pick.sv | 25 ++
 rtl/rr_burst_arbiter.sv | 106 ++++++++++
 tb/tb_rr_burst_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Index helpers work on MAX_REQ-wide vectors; callers zero-extend and pass their own N_REQ.
package rr_burst_arbiter_pkg;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_ID_W  = 4;
    localparam int unsigned DEF_LEN_W = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef logic [DEF_LEN_W-1:0] len_t;
    typedef logic [MAX_REQ-1:0]   req_vec_t;
    typedef logic [MAX_ID_W-1:0]  idx_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    // First asserted request at or after ptr, scanning upward and wrapping modulo n.
    function automatic pick_t rr_pick(req_vec_t req, idx_t ptr, int unsigned n);
        pick_t       p;
        int unsigned pos;
        p = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= n) begin
                pos = pos - n;
            end
            if (i < n && pos < MAX_REQ) begin
                if (!p.found && req[pos[3:0]]) begin
                    p.found = 1'b1;
                    p.idx   = pos[3:0];
                end
            end
        end
        return p;
    endfunction

    function automatic req_vec_t onehot(idx_t idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Requester/resource-side bundle of the burst arbiter.
// The arbiter takes the slave view; requesters and the resource model take the master view.
interface rr_burst_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic                   beat_ack;
    logic [N_REQ-1:0]       gnt;
    logic [ID_W-1:0]        gnt_id;
    logic                   busy;
    logic                   done;
    logic [LEN_W-1:0]       beats_left;

    modport slave (
        input  req,
        input  req_len,
        input  beat_ack,
        output gnt,
        output gnt_id,
        output busy,
        output done,
        output beats_left
    );

    modport master (
        output req,
        output req_len,
        output beat_ack,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  done,
        input  beats_left
    );

endinterface

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational rotate-priority encoder: picks the first asserted request at or after ptr.
module rr_pick_comb
    import rr_burst_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  sel,
    output logic             found
);

    req_vec_t req_ext;
    pick_t    pick;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req;
        pick                 = rr_pick(req_ext, idx_t'(ptr), N_REQ);
        sel                  = ID_W'(pick.idx);
        found                = pick.found;
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester a shared resource for a whole burst.
// Grant is locked until the last beat is acknowledged; the pointer then moves past the owner.
module rr_burst_arbiter
    import rr_burst_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic        clk,
    input  logic        rst,
    rr_burst_if.slave   bus
);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic [ID_W-1:0]    sel;
    logic               found;
    logic [LEN_W-1:0]   len_sel;

    rr_pick_comb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .sel   (sel),
        .found (found)
    );

    assign len_sel = bus.req_len[sel*LEN_W +: LEN_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            left_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            left_q  <= left_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        left_d  = left_q;
        ptr_d   = ptr_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = N_REQ'(onehot(idx_t'(sel)));
                    id_d    = sel;
                    busy_d  = 1'b1;
                    // A declared length of zero still moves one beat.
                    left_d  = (len_sel == '0) ? LEN_W'(1) : len_sel;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.beat_ack) begin
                    if (left_q > LEN_W'(1)) begin
                        left_d = left_q - LEN_W'(1);
                    end else begin
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        left_d  = '0;
                        done_d  = 1'b1;
                        ptr_d   = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_id     = id_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.beats_left = left_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_gnt_busy:    assert property (@(posedge clk) disable iff (rst) ((gnt_q != '0) == busy_q));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed self-checking bench for rr_burst_arbiter with hand-computed expectations.
module tb_rr_burst_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned ID_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    rr_burst_if #(.N_REQ(N_REQ), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

    rr_burst_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},  32'(bus.gnt), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_left"}, 32'(bus.beats_left), 32'h0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_len  = '0;
        bus.beat_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_len  = '0;
        bus.beat_ack = 1'b0;

        // Reset state
        do_reset();
        check_idle("rst");
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_id",   32'(bus.gnt_id), 32'h0);

        // beat_ack while idle is ignored
        bus.beat_ack = 1'b1;
        tick();
        check_idle("idle_ack");
        check("idle_ack_done", 32'(bus.done), 32'h0);

        // Single requester 2, length 3
        bus.req     = 4'b0100;
        bus.req_len = 16'h0300;
        tick();
        check("t1_gnt",  32'(bus.gnt), 32'h4);
        check("t1_id",   32'(bus.gnt_id), 32'h2);
        check("t1_busy", 32'(bus.busy), 32'h1);
        check("t1_left3", 32'(bus.beats_left), 32'h3);
        bus.req = '0;
        tick();
        check("t1_left2", 32'(bus.beats_left), 32'h2);
        tick();
        check("t1_left1", 32'(bus.beats_left), 32'h1);
        check("t1_done_early", 32'(bus.done), 32'h0);
        tick();
        check("t1_done", 32'(bus.done), 32'h1);
        check_idle("t1_end");
        tick();
        check("t1_done_pulse", 32'(bus.done), 32'h0);

        // Wrap-around: pointer is 3 after granting 2
        bus.req     = 4'b1001;
        bus.req_len = 16'h1111;
        tick();
        check("t4_gnt3", 32'(bus.gnt), 32'h8);
        check("t4_id3",  32'(bus.gnt_id), 32'h3);
        tick();
        check("t4_done3", 32'(bus.done), 32'h1);
        check("t4_bubble", 32'(bus.gnt), 32'h0);
        tick();
        check("t4_gnt0", 32'(bus.gnt), 32'h1);
        check("t4_id0",  32'(bus.gnt_id), 32'h0);
        bus.req = '0;
        tick();
        check("t4_done0", 32'(bus.done), 32'h1);

        // All requesting, length 1: order 0,1,2,3,0 with a bubble between bursts
        do_reset();
        bus.req      = 4'b1111;
        bus.req_len  = 16'h1111;
        bus.beat_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t2_gnt%0d", k), 32'(bus.gnt), 32'(1) << (k % 4));
            tick();
            check($sformatf("t2_done%0d", k), 32'(bus.done), 32'h1);
            check($sformatf("t2_bub%0d", k), 32'(bus.gnt), 32'h0);
        end
        bus.req = '0;

        // Owner drops req mid-burst; grant stays locked
        do_reset();
        bus.req      = 4'b0001;
        bus.req_len  = 16'h0004;
        tick();
        check("t3_gnt", 32'(bus.gnt), 32'h1);
        check("t3_left4", 32'(bus.beats_left), 32'h4);
        tick();
        check("t3_noack", 32'(bus.beats_left), 32'h4);
        bus.beat_ack = 1'b1;
        tick();
        tick();
        check("t3_left2", 32'(bus.beats_left), 32'h2);
        bus.req = '0;
        tick();
        check("t3_held_gnt", 32'(bus.gnt), 32'h1);
        check("t3_left1", 32'(bus.beats_left), 32'h1);
        tick();
        check("t3_done", 32'(bus.done), 32'h1);
        check_idle("t3_end");

        // Zero length counts as one beat
        bus.beat_ack = 1'b0;
        bus.req      = 4'b0010;
        bus.req_len  = 16'h0000;
        tick();
        check("t5_gnt", 32'(bus.gnt), 32'h2);
        check("t5_left", 32'(bus.beats_left), 32'h1);
        bus.req      = '0;
        bus.beat_ack = 1'b1;
        tick();
        check("t5_done", 32'(bus.done), 32'h1);
        check("t5_left0", 32'(bus.beats_left), 32'h0);

        // Asynchronous reset mid-burst
        bus.req     = 4'b1000;
        bus.req_len = 16'h3000;
        tick();
        check("t6_gnt", 32'(bus.gnt), 32'h8);
        tick();
        check("t6_left2", 32'(bus.beats_left), 32'h2);
        rst = 1'b1;
        #1;
        check_idle("t6_async");
        check("t6_id", 32'(bus.gnt_id), 32'h0);
        bus.req = '0;
        tick();
        check("t6_nodone", 32'(bus.done), 32'h0);
        rst          = 1'b0;
        bus.beat_ack = 1'b0;
        bus.req      = 4'b1010;
        bus.req_len  = 16'h1111;
        tick();
        check("t6_ptr0_gnt", 32'(bus.gnt), 32'h2);
        check("t6_ptr0_id",  32'(bus.gnt_id), 32'h1);
        check("t6_nodone2",  32'(bus.done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
